// File: rtl/mcp2515_pkg.sv
// mcp2515_pkg: shared opcodes, command/state encodings and frame-length helper for the MCP2515 SPI sequencer.
package mcp2515_pkg;
    localparam logic [7:0] OP_RESET  = 8'hC0;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_WRITE  = 8'h02;
    localparam logic [7:0] OP_BITMOD = 8'h05;
    localparam logic [7:0] OP_RDSTAT = 8'hA0;
    localparam logic [7:0] OP_RTS    = 8'h80;

    typedef enum logic [2:0] {
        CMD_RESET  = 3'd0,
        CMD_READ   = 3'd1,
        CMD_WRITE  = 3'd2,
        CMD_BITMOD = 3'd3,
        CMD_RDSTAT = 3'd4,
        CMD_RTS    = 3'd5
    } cmd_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_e;

    function automatic logic [3:0] frame_last(input cmd_op_e op, input logic [3:0] len);
        return op == CMD_READ   ? len + 4'd1 :
               op == CMD_WRITE  ? 4'd2 :
               op == CMD_BITMOD ? 4'd3 :
               op == CMD_RDSTAT ? 4'd1 : 4'd0;
    endfunction
endpackage

// File: rtl/mcp2515_spi_sequencer_if.sv
// mcp2515_spi_sequencer_if: host command/response and SPI byte-master handshake signals.
interface mcp2515_spi_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic [7:0] cmd_mask;
    logic [3:0] cmd_len;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_last;
    logic       busy;
    logic       err;
    logic       cs_n;
    logic       spi_start;
    logic [7:0] spi_tx_byte;
    logic       spi_done;
    logic [7:0] spi_rx_byte;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_len, spi_done, spi_rx_byte,
        output cmd_ready, rsp_valid, rsp_data, rsp_last, busy, err, cs_n, spi_start, spi_tx_byte
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, cmd_len, spi_done, spi_rx_byte,
        input  cmd_ready, rsp_valid, rsp_data, rsp_last, busy, err, cs_n, spi_start, spi_tx_byte
    );
endinterface

// File: rtl/mcp2515_byte_sel.sv
// mcp2515_byte_sel: picks the byte to transmit at a frame position and flags dummy (data) positions.
module mcp2515_byte_sel
    import mcp2515_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  cmd_op_e          op,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       addr,
    input  logic [7:0]       mask,
    input  logic [7:0]       wdata,
    output logic [7:0]       tx_byte,
    output logic             is_data
);
    logic i0, i1, i2;

    assign i0 = idx == IDX_W'(0);
    assign i1 = idx == IDX_W'(1);
    assign i2 = idx == IDX_W'(2);

    always_comb begin
        tx_byte = 8'h00;
        is_data = 1'b0;
        case (op)
            CMD_RESET:  tx_byte = OP_RESET;
            CMD_READ: begin
                tx_byte = i0 ? OP_READ : i1 ? addr : 8'h00;
                is_data = !i0 && !i1;
            end
            CMD_WRITE:  tx_byte = i0 ? OP_WRITE : i1 ? addr : wdata;
            CMD_BITMOD: tx_byte = i0 ? OP_BITMOD : i1 ? addr : i2 ? mask : wdata;
            CMD_RDSTAT: begin
                tx_byte = i0 ? OP_RDSTAT : 8'h00;
                is_data = !i0;
            end
            CMD_RTS:    tx_byte = OP_RTS | {5'd0, addr[2:0]};
            default:    tx_byte = 8'h00;
        endcase
    end
endmodule

// File: rtl/mcp2515_spi_sequencer.sv
// mcp2515_spi_sequencer: frames MCP2515 SPI instructions with chip-select over a byte-level SPI master.
// Define SEQ_TIMEOUT_EN to add a per-byte spi_done watchdog that aborts a stalled frame.
module mcp2515_spi_sequencer
    import mcp2515_pkg::*;
#(
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_GAP_CYC   = 4,
    parameter int MAX_BURST    = 8,
    parameter int TIMEOUT_CYC  = 4096
) (
    input logic clk_50MHz,
    input logic reset,
    mcp2515_spi_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(MAX_BURST + 4);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e           state, state_d;
    cmd_op_e          op_q;
    logic [7:0]       addr_q, wdata_q, mask_q, tx_q, sel_byte, rsp_data_q;
    logic [IDX_W-1:0] idx, idx_d, last_q;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             sel_data, data_q, rsp_valid_q, rsp_last_q, err_q;
    logic             legal, accept, bad, done_byte, last_byte, tmo, rsp_ev;

    assign legal = bus.cmd_op <= 3'd5 &&
                   (bus.cmd_op != CMD_READ || (bus.cmd_len != 4'd0 && 32'(bus.cmd_len) <= MAX_BURST));
    assign accept    = state == S_IDLE && bus.cmd_valid && legal;
    assign bad       = state == S_IDLE && bus.cmd_valid && !legal;
    assign done_byte = state == S_WAIT && bus.spi_done;
    assign last_byte = idx == last_q;
`ifdef SEQ_TIMEOUT_EN
    assign tmo = state == S_WAIT && !bus.spi_done && cnt == CNT_W'(TIMEOUT_CYC - 1);
`else
    assign tmo = 1'b0;
`endif
    // A timed-out read still closes the host transaction with a single FF terminator.
    assign rsp_ev = (done_byte && data_q) || (tmo && (op_q == CMD_READ || op_q == CMD_RDSTAT));

    assign bus.cmd_ready   = state == S_IDLE;
    assign bus.busy        = state != S_IDLE;
    assign bus.cs_n        = !(state == S_SETUP || state == S_ISSUE || state == S_WAIT);
    assign bus.spi_start   = state == S_ISSUE;
    assign bus.spi_tx_byte = tx_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_last    = rsp_last_q;
    assign bus.err         = err_q;

    // Selects on the next index so spi_tx_byte is already valid when spi_start rises.
    mcp2515_byte_sel #(.IDX_W(IDX_W)) u_byte_sel (
        .op      (op_q),
        .idx     (idx_d),
        .addr    (addr_q),
        .mask    (mask_q),
        .wdata   (wdata_q),
        .tx_byte (sel_byte),
        .is_data (sel_data)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        idx_d   = idx;
        case (state)
            S_IDLE: begin
                state_d = accept ? S_SETUP : S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
            S_SETUP: state_d = cnt == CNT_W'(CS_SETUP_CYC - 1) ? S_ISSUE : S_SETUP;
            S_ISSUE: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (done_byte) begin
                    state_d = last_byte ? S_GAP : S_ISSUE;
                    idx_d   = idx + 1'b1;
                    cnt_d   = '0;
                end else if (tmo) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP:   state_d = cnt == CNT_W'(CS_GAP_CYC - 1) ? S_IDLE : S_GAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            last_q      <= '0;
            op_q        <= CMD_RESET;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            mask_q      <= 8'h00;
            tx_q        <= 8'h00;
            data_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt <= cnt_d;
            idx <= idx_d;
            if (accept) begin
                op_q    <= cmd_op_e'(bus.cmd_op);
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
                mask_q  <= bus.cmd_mask;
                last_q  <= IDX_W'(frame_last(cmd_op_e'(bus.cmd_op), bus.cmd_len));
            end
            if (state_d == S_ISSUE && state != S_ISSUE) begin
                tx_q   <= sel_byte;
                data_q <= sel_data;
            end
            rsp_valid_q <= rsp_ev;
            rsp_last_q  <= rsp_ev && (!done_byte || last_byte);
            if (rsp_ev)
                rsp_data_q <= done_byte ? bus.spi_rx_byte : 8'hFF;
            err_q <= bad || tmo || (err_q && !accept);
        end
    end
endmodule
